// File: rtl/quad_dec_pkg.sv
// Shared types for the quadrature decoder: Gray-coded phases, FSM states,
// and the phase-step classifier.
package quad_dec_pkg;

  localparam int NUM_CH = 2;

  typedef enum logic [1:0] {
    PH0 = 2'b00,
    PH1 = 2'b01,
    PH2 = 2'b11,
    PH3 = 2'b10
  } phase_t;

  typedef enum logic {
    ST_INIT,
    ST_TRACK
  } state_t;

  typedef enum logic [1:0] {
    STEP_NONE = 2'd0,
    STEP_UP   = 2'd1,
    STEP_DN   = 2'd2,
    STEP_ILL  = 2'd3
  } step_t;

  function automatic phase_t ph_next(input phase_t p);
    case (p)
      PH0:     return PH1;
      PH1:     return PH2;
      PH2:     return PH3;
      default: return PH0;
    endcase
  endfunction

  // Anything that is neither a hold nor a single forward/backward step is a
  // two-position jump, i.e. both channels moved on the same edge.
  function automatic step_t step_dir(input phase_t prev, input phase_t cur);
    if (cur == prev)               return STEP_NONE;
    else if (cur == ph_next(prev)) return STEP_UP;
    else if (prev == ph_next(cur)) return STEP_DN;
    else                           return STEP_ILL;
  endfunction

endpackage

// File: rtl/input_debounce.sv
// 2-FF synchroniser followed by a run-length debounce filter: the filtered bit
// follows the synchronised bit only after DEBOUNCE_CYCLES consecutive differing samples.
module input_debounce
  import quad_dec_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sync <= '0;
      cnt  <= '0;
      o_q  <= 1'b0;
    end else begin
      sync <= {sync[0], i_d};
      if (sync[1] == o_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        o_q <= sync[1];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature front-end: debounces A/B, decodes Gray-code phase steps into
// counter enable/direction pulses, and flags illegal two-position jumps.
module quadrature_decoder
  import quad_dec_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_a,
  input  logic i_b,
  output logic o_en,
  output logic o_up_down,
  output logic o_err
);

  // INIT must outlast the sync + debounce path so the phase captured at exit
  // already reflects inputs held across reset release.
  localparam int                INIT_W    = $clog2(DEBOUNCE_CYCLES + 3);
  localparam logic [INIT_W-1:0] INIT_LAST = INIT_W'(DEBOUNCE_CYCLES + 2);

  logic [NUM_CH-1:0] raw, filt;
  assign raw = {i_a, i_b};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    input_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_deb (
      .i_clk  (i_clk),
      .i_rst_n(i_rst_n),
      .i_d    (raw[c]),
      .o_q    (filt[c])
    );
  end

  phase_t            cur_ph, prev_ph, prev_nxt;
  state_t            state, state_nxt;
  step_t             step;
  logic [INIT_W-1:0] init_cnt, init_nxt;
  logic              en_nxt, err_nxt, dir_nxt;

  assign cur_ph = phase_t'(filt);
  assign step   = step_dir(prev_ph, cur_ph);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      prev_ph   <= PH0;
      o_en      <= 1'b0;
      o_err     <= 1'b0;
      o_up_down <= 1'b0;
    end else begin
      state     <= state_nxt;
      init_cnt  <= init_nxt;
      prev_ph   <= prev_nxt;
      o_en      <= en_nxt;
      o_err     <= err_nxt;
      o_up_down <= dir_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    init_nxt  = init_cnt;
    prev_nxt  = prev_ph;
    en_nxt    = 1'b0;
    err_nxt   = 1'b0;
    dir_nxt   = o_up_down;
    case (state)
      ST_INIT: begin
        if (init_cnt == INIT_LAST) begin
          state_nxt = ST_TRACK;
          init_nxt  = '0;
          prev_nxt  = cur_ph;
        end else begin
          init_nxt = init_cnt + 1'b1;
        end
      end
      default: begin
        prev_nxt = cur_ph;
        case (step)
          STEP_UP:  begin en_nxt = 1'b1; dir_nxt = 1'b1; end
          STEP_DN:  begin en_nxt = 1'b1; dir_nxt = 1'b0; end
          STEP_ILL: err_nxt = 1'b1;
          default:  ;
        endcase
      end
    endcase
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed scenarios plus random phase walks, every cycle checked against a
// run-length / modular-arithmetic reference model of the decoder.
module tb_quadrature_decoder;

  localparam int D = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0, b = 1'b0;
  logic en, up, err;

  int tests = 0, fails = 0;
  int en_cnt = 0, err_cnt = 0;
  int q = 0;

  always #5 clk = ~clk;

  quadrature_decoder #(.DEBOUNCE_CYCLES(D)) dut (
    .i_clk    (clk),
    .i_rst_n  (rst_n),
    .i_a      (a),
    .i_b      (b),
    .o_en     (en),
    .o_up_down(up),
    .o_err    (err)
  );

  // Reference model state
  logic [1:0] m_s1 = 2'b00, m_s2 = 2'b00, m_filt = 2'b00;
  logic [1:0] m_hist[$];
  int   m_prev = 0, m_n = 0;
  logic m_en = 1'b0, m_err = 1'b0, m_up = 1'b0;
  // {a,b} -> position on the ring: 00->0, 01->1, 10->3, 11->2 (self-inverse)
  int   ring[4] = '{0, 1, 3, 2};

  task automatic model_edge();
    logic [1:0] f_pre;
    bit all_diff;
    int d;
    f_pre = m_filt;
    m_en  = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      m_s1 = 2'b00; m_s2 = 2'b00; m_filt = 2'b00;
      m_hist.delete();
      m_prev = 0; m_n = 0; m_up = 1'b0;
      return;
    end
    m_n++;
    // Filtered bit flips once the last D synchronised samples all disagree with it.
    m_hist.push_back(m_s2);
    if (m_hist.size() > D) void'(m_hist.pop_front());
    if (m_hist.size() == D) begin
      for (int c = 0; c < 2; c++) begin
        all_diff = 1'b1;
        foreach (m_hist[i]) if (m_hist[i][c] == f_pre[c]) all_diff = 1'b0;
        if (all_diff) m_filt[c] = ~f_pre[c];
      end
    end
    m_s2 = m_s1;
    m_s1 = {a, b};
    if (m_n == D + 3) begin
      m_prev = ring[f_pre];
    end else if (m_n >= D + 4) begin
      d = (ring[f_pre] - m_prev + 4) % 4;
      if (d == 1)      begin m_en = 1'b1; m_up = 1'b1; end
      else if (d == 3) begin m_en = 1'b1; m_up = 1'b0; end
      else if (d == 2) m_err = 1'b1;
      m_prev = ring[f_pre];
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s t=%0t got %0d exp %0d", tag, $time, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    model_edge();
    @(posedge clk);
    #1;
    chk("o_en", int'(en), int'(m_en));
    chk("o_err", int'(err), int'(m_err));
    chk("o_up_down", int'(up), int'(m_up));
    chk("en_err_excl", int'(en & err), 0);
    if (en) begin
      en_cnt++;
      q = up ? (q + 1) % 3 : (q + 2) % 3;
    end
    if (err) err_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic set_ab(input logic [1:0] v);
    a = v[1];
    b = v[0];
  endtask

  task automatic clr();
    en_cnt  = 0;
    err_cnt = 0;
  endtask

  initial begin
    int cur;
    int r, stp;
    logic [1:0] fwd[4];
    logic [1:0] bwd[4];
    fwd = '{2'b01, 2'b11, 2'b10, 2'b00};
    bwd = '{2'b10, 2'b11, 2'b01, 2'b00};

    // Reset state
    rst_n = 1'b0;
    set_ab(2'b00);
    run(3);
    chk("rst_en", int'(en), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_up", int'(up), 0);
    rst_n = 1'b1;
    run(20);

    // Forward sequence
    clr();
    for (int i = 0; i < 4; i++) begin
      set_ab(fwd[i]);
      run(10);
    end
    chk("fwd_en_cnt", en_cnt, 4);
    chk("fwd_err_cnt", err_cnt, 0);
    chk("fwd_dir", int'(up), 1);

    // Backward sequence
    clr();
    for (int i = 0; i < 4; i++) begin
      set_ab(bwd[i]);
      run(10);
    end
    chk("bwd_en_cnt", en_cnt, 4);
    chk("bwd_dir", int'(up), 0);

    // Glitch shorter than the filter, then a pulse just long enough
    clr();
    set_ab(2'b10); run(3);
    set_ab(2'b00); run(15);
    chk("glitch_en_cnt", en_cnt, 0);
    chk("glitch_err_cnt", err_cnt, 0);
    clr();
    set_ab(2'b10); run(5);
    set_ab(2'b00); run(3);
    chk("pulse_en_cnt", en_cnt, 1);
    chk("pulse_dir", int'(up), 0);
    run(15);

    // Double transition 00->11 then a legal 11->10
    clr();
    set_ab(2'b11); run(10);
    chk("dbl_err_cnt", err_cnt, 1);
    chk("dbl_en_cnt", en_cnt, 0);
    clr();
    set_ab(2'b10); run(10);
    chk("after_dbl_en", en_cnt, 1);
    chk("after_dbl_dir", int'(up), 1);
    set_ab(2'b00); run(10);

    // Reset mid-debounce with inputs held at 11 across release
    set_ab(2'b11); run(2);
    rst_n = 1'b0;
    run(3);
    chk("mid_rst_en", int'(en), 0);
    chk("mid_rst_err", int'(err), 0);
    chk("mid_rst_up", int'(up), 0);
    rst_n = 1'b1;
    clr();
    run(20);
    chk("init_exit_en", en_cnt, 0);
    chk("init_exit_err", err_cnt, 0);
    set_ab(2'b10); run(10);
    chk("post_init_en", en_cnt, 1);
    chk("post_init_dir", int'(up), 1);
    set_ab(2'b00); run(10);

    // Driving a mod-3 counter with five forward steps
    q = 0;
    for (int i = 0; i < 5; i++) begin
      set_ab(fwd[i % 4]);
      run(10);
      chk("mod3_q", q, (i + 1) % 3);
    end

    // Random walk: mostly single steps, some double jumps, random hold times
    cur = ring[{a, b}];
    for (int i = 0; i < 200; i++) begin
      r   = int'($urandom_range(0, 9));
      stp = (r < 4) ? 1 : (r < 8) ? 3 : 2;
      cur = (cur + stp) % 4;
      set_ab(2'(ring[cur]));
      run(int'($urandom_range(1, 12)));
    end
    run(20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
